imem_loader: RTL and testbench

Boot-time writer for the single-cycle MIPS core's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is written into instruction memory, and the core is held in reset until a complete image has loaded with a good checksum. It sits between the host byte source and the instruction-memory write port, on the supply side of the fetched op/funct stream.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/word_assembler.sv | 68 ++++++
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory boot loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_e;

    localparam int HDR_W          = 16;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - big-endian byte-to-word shifter with lane counter, XOR accumulator and word_ready pulse
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        lane_last_o,
    output logic [31:0] word_o,
    output logic        word_ready_o,
    output logic [7:0]  acc_o
);

    localparam int                LANE_W    = $clog2(BYTES_PER_WORD);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [23:0]       shift_q, shift_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        acc_q, acc_d;
    logic              word_ready_q, word_ready_d;

    // word_q is only reloaded on the lane-3 byte, so it stays stable for the write cycle
    always_comb begin
        lane_d       = lane_q;
        shift_d      = shift_q;
        word_d       = word_q;
        acc_d        = acc_q;
        word_ready_d = 1'b0;
        if (clear_i) begin
            lane_d  = '0;
            shift_d = '0;
            acc_d   = '0;
        end else if (byte_valid_i) begin
            shift_d = {shift_q[15:0], byte_i};
            acc_d   = acc_q ^ byte_i;
            lane_d  = lane_q + LANE_W'(1);
            if (lane_q == LAST_LANE) begin
                word_d       = {shift_q, byte_i};
                word_ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q       <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            acc_q        <= '0;
            word_ready_q <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            acc_q        <= acc_d;
            word_ready_q <= word_ready_d;
        end
    end

    assign lane_last_o  = (lane_q == LAST_LANE);
    assign word_o       = word_q;
    assign word_ready_o = word_ready_q;
    assign acc_o        = acc_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the MIPS instruction memory; holds the core until a verified image is in place
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [HDR_W:0] DEPTH = (HDR_W + 1)'(1) << ADDR_W;

    state_e            state_q;
    logic [HDR_W-1:0]  n_q, n_d;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic              hold_q, done_q, err_q;

    logic              accept, rearm, asm_clear, asm_valid;
    logic              hdr_bad, last_word;
    logic              lane_last, word_ready;
    logic [31:0]       word;
    logic [7:0]        acc;

    assign in_ready  = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                       (state_q == DATA)   || (state_q == CHECK);
    assign accept    = in_valid && in_ready;
    assign rearm     = start && ((state_q == DONE) || (state_q == ERR));
    assign n_d       = {n_q[HDR_W-1:8], in_data};
    assign hdr_bad   = (n_d == '0) || ({1'b0, n_d} > DEPTH);
    assign last_word = (HDR_W'(idx_q) + HDR_W'(1)) == n_q;
    assign asm_clear = rearm || (accept && (state_q == HDR_LO));
    assign asm_valid = accept && (state_q == DATA);

    word_assembler u_asm (
        .clk          (clk),
        .rst_n        (reset),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_valid),
        .byte_i       (in_data),
        .lane_last_o  (lane_last),
        .word_o       (word),
        .word_ready_o (word_ready),
        .acc_o        (acc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HDR_HI;
            n_q     <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // The index advances at the end of the write cycle, so imem_addr shows the pre-increment value
            if (word_ready) begin
                idx_q <= idx_q + 1'b1;
            end
            case (state_q)
                HDR_HI: begin
                    if (accept) begin
                        n_q[HDR_W-1:8] <= in_data;
                        state_q        <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        n_q <= n_d;
                        if (hdr_bad) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept && lane_last) begin
                        addr_q <= idx_q[ADDR_W-1:0];
                        if (last_word) begin
                            state_q <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (in_data == acc) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                    if (start) begin
                        state_q <= HDR_HI;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        hold_q  <= 1'b1;
                        idx_q   <= '0;
                        addr_q  <= '0;
                    end
                end
                default: begin
                    state_q <= HDR_HI;
                end
            endcase
        end
    end

    assign imem_we      = word_ready;
    assign imem_wd      = word;
    assign imem_addr    = addr_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = idx_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with a stream-level expected-write model
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              start    = 1'b0;
    logic [7:0]        in_data  = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready, imem_we, cpu_hold, load_done, load_error;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wd      (imem_wd),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    typedef struct {
        int          due;
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          cap_addr[$];
    logic [31:0] cap_data[$];
    logic [7:0]  stream_q[$];
    int          start_at = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every cycle: writes must match the stream model in cycle, address and data
    always begin
        wr_t e;
        @(negedge clk);
        #1;
        if (reset) begin
            if (imem_we) begin
                wr_count++;
                cap_addr.push_back(int'(imem_addr));
                cap_data.push_back(imem_wd);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %h at cycle %0d, none expected", imem_addr, imem_wd, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("write_cycle", 64'(cyc), 64'(e.due));
                    check("write_addr", 64'(imem_addr), 64'(e.addr));
                    check("write_data", 64'(imem_wd), 64'(e.data));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_write: no imem_we, expected addr %0d data %h at cycle %0d", exp_q[0].addr, exp_q[0].data, exp_q[0].due);
                exp_q.delete(0);
            end
            check("hold_vs_done", 64'(cpu_hold), 64'(!load_done));
            check("ready_vs_status", 64'(in_ready), 64'(!(load_done || load_error)));
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
        int waited;
        waited  = 0;
        acc_cyc = -1;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        while (acc_cyc < 0 && waited < 50) begin
            if (in_ready) acc_cyc = cyc;
            @(negedge clk);
            waited++;
        end
        in_valid = 1'b0;
        if (acc_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL byte_accept: byte %h not taken, in_ready=%b, required 1 within 50 cycles", b, in_ready);
        end
    endtask

    task automatic run_stream(input bit gaps, output bit exp_done, output int exp_words);
        int         nv;
        bit         hv;
        logic [7:0] x;
        int         c;
        wr_t        e;
        nv        = 0;
        hv        = 1'b0;
        x         = 8'h00;
        exp_words = 0;
        for (int i = 0; i < stream_q.size(); i++) begin
            if (i == start_at) start = 1'b1;
            send_byte(stream_q[i], gaps ? int'($urandom_range(0, 2)) : 0, c);
            start = 1'b0;
            if (i == 1) begin
                nv = int'({stream_q[0], stream_q[1]});
                hv = (nv != 0) && (nv <= DEPTH);
            end
            if (i >= 2 && hv && i < 2 + 4 * nv) begin
                x ^= stream_q[i];
                if ((i - 2) % 4 == 3) begin
                    e.due  = c + 1;
                    e.addr = (i - 2) / 4;
                    e.data = {stream_q[i-3], stream_q[i-2], stream_q[i-1], stream_q[i]};
                    exp_q.push_back(e);
                    exp_words++;
                end
            end
        end
        exp_done = hv && (stream_q.size() == 3 + 4 * nv) && (stream_q[stream_q.size()-1] == x);
    endtask

    task automatic rearm();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rearm_ready", 64'(in_ready), 64'd1);
        check("rearm_words", 64'(words_loaded), 64'd0);
        check("rearm_hold", 64'(cpu_hold), 64'd1);
        check("rearm_done", 64'(load_done), 64'd0);
        check("rearm_err", 64'(load_error), 64'd0);
        check("rearm_addr", 64'(imem_addr), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ed;
        int          ew;
        int          base;
        logic [31:0] w;
        logic [7:0]  cs;

        // 1: reset state
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_hold", 64'(cpu_hold), 64'd1);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_we", 64'(imem_we), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_err", 64'(load_error), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);

        // 2: two-word image, checksum 20^08^00^05^01^09^50^20 = 0x55
        stream_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
        base = cap_data.size();
        run_stream(1'b0, ed, ew);
        check("t2_done", 64'(load_done), 64'd1);
        check("t2_hold", 64'(cpu_hold), 64'd0);
        check("t2_model_done", 64'(load_done), 64'(ed));
        check("t2_words", 64'(words_loaded), 64'd2);
        #2;
        check("t2_nwrites", 64'(cap_data.size() - base), 64'd2);
        if (cap_data.size() == base + 2) begin
            check("t2_w0_data", 64'(cap_data[base]), 64'h20080005);
            check("t2_w0_addr", 64'(cap_addr[base]), 64'd0);
            check("t2_w1_data", 64'(cap_data[base+1]), 64'h01095020);
            check("t2_w1_addr", 64'(cap_addr[base+1]), 64'd1);
        end
        rearm();

        // 3: bad checksum
        stream_q[stream_q.size()-1] = 8'h00;
        base = wr_count;
        run_stream(1'b0, ed, ew);
        check("t3_err", 64'(load_error), 64'd1);
        check("t3_model_err", 64'(load_error), 64'(!ed));
        check("t3_hold", 64'(cpu_hold), 64'd1);
        check("t3_ready", 64'(in_ready), 64'd0);
        #2;
        check("t3_nwrites", 64'(wr_count - base), 64'd2);
        rearm();

        // 4: oversize and zero headers
        stream_q = '{8'h00, 8'h41};
        base = wr_count;
        run_stream(1'b0, ed, ew);
        check("t4a_err", 64'(load_error), 64'd1);
        check("t4a_model_err", 64'(load_error), 64'(!ed));
        #2;
        check("t4a_nwrites", 64'(wr_count - base), 64'd0);
        rearm();
        stream_q = '{8'h00, 8'h00};
        run_stream(1'b0, ed, ew);
        check("t4b_err", 64'(load_error), 64'd1);
        #2;
        check("t4b_nwrites", 64'(wr_count - base), 64'd0);
        rearm();

        // 5: gapped partial word, reset mid-word, then N=1 load
        stream_q = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        base = wr_count;
        run_stream(1'b1, ed, ew);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t5_rst_we", 64'(imem_we), 64'd0);
        check("t5_rst_addr", 64'(imem_addr), 64'd0);
        check("t5_rst_wd", 64'(imem_wd), 64'd0);
        check("t5_rst_hold", 64'(cpu_hold), 64'd1);
        check("t5_rst_done", 64'(load_done), 64'd0);
        check("t5_rst_err", 64'(load_error), 64'd0);
        check("t5_rst_words", 64'(words_loaded), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_nwrites", 64'(wr_count - base), 64'd0);
        check("t5_ready", 64'(in_ready), 64'd1);
        stream_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        base = cap_data.size();
        run_stream(1'b1, ed, ew);
        check("t5_done", 64'(load_done), 64'd1);
        check("t5_words", 64'(words_loaded), 64'd1);
        #2;
        check("t5_nwrites2", 64'(cap_data.size() - base), 64'd1);
        if (cap_data.size() == base + 1) begin
            check("t5_w_data", 64'(cap_data[base]), 64'hDEADBEEF);
            check("t5_w_addr", 64'(cap_addr[base]), 64'd0);
        end
        rearm();

        // 6: full 64-word image, start pulsed mid-payload
        stream_q = '{8'h00, 8'h40};
        cs = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            w = {8'(i), 8'(i + 1), 8'hA5, 8'(~i)};
            for (int k = 3; k >= 0; k--) begin
                stream_q.push_back(w[k*8 +: 8]);
                cs ^= w[k*8 +: 8];
            end
        end
        stream_q.push_back(cs);
        start_at = 100;
        base = cap_data.size();
        run_stream(1'b0, ed, ew);
        start_at = -1;
        check("t6_done", 64'(load_done), 64'd1);
        check("t6_model_done", 64'(load_done), 64'(ed));
        check("t6_words", 64'(words_loaded), 64'(DEPTH));
        #2;
        check("t6_nwrites", 64'(cap_data.size() - base), 64'(DEPTH));
        if (cap_data.size() == base + DEPTH) begin
            check("t6_first_addr", 64'(cap_addr[base]), 64'd0);
            check("t6_last_addr", 64'(cap_addr[base+DEPTH-1]), 64'd63);
            check("t6_last_data", 64'(cap_data[base+DEPTH-1]), 64'h3F40A5C0);
        end

        repeat (3) @(negedge clk);
        check("no_pending_writes", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
